// File: rtl/count_pkg.sv
// Shared definitions for the BCD counter family: digit type, digit limit,
// timer state encoding and a digit-legality helper.
package count_pkg;

    typedef logic [3:0] bcd_digit_t;

    localparam bcd_digit_t BCD_MAX = 4'd9;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ARMED = 2'd1,
        RUN   = 2'd2,
        DONE  = 2'd3
    } timer_state_t;

    // A nibble is a legal BCD digit when it does not exceed 9.
    function automatic logic digit_is_valid(input bcd_digit_t d);
        return (d <= BCD_MAX);
    endfunction

endpackage

// File: rtl/bcd_digit_dec.sv
// Single BCD digit decrementer. A borrow into digit 0 wraps it to 9 and
// propagates the borrow upward; any other digit absorbs the borrow.
module bcd_digit_dec
    import count_pkg::*;
(
    input  bcd_digit_t digit_in,
    input  logic       borrow_in,
    output bcd_digit_t digit_out,
    output logic       borrow_out
);

    // Decrement one digit when a borrow arrives, wrapping 0 -> 9.
    always_comb begin
        digit_out  = digit_in;
        borrow_out = 1'b0;
        if (borrow_in) begin
            if (digit_in == 4'd0) begin
                digit_out  = BCD_MAX;
                borrow_out = 1'b1;
            end else begin
                digit_out  = digit_in - 4'd1;
                borrow_out = 1'b0;
            end
        end else begin
            digit_out  = digit_in;
            borrow_out = 1'b0;
        end
    end

endmodule

// File: rtl/bcd_down_timer.sv
// Loadable multi-digit BCD down-counter with load handshake, start, pause,
// abort, a one-cycle done pulse at zero and a one-cycle err pulse on a
// rejected (non-BCD) load.
module bcd_down_timer
    import count_pkg::*;
#(
    parameter int DIGITS = 2
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                load_valid,
    input  logic [4*DIGITS-1:0] load_bcd,
    output logic                load_ready,
    input  logic                start,
    input  logic                en,
    input  logic                abort,
    output logic [4*DIGITS-1:0] q,
    output logic                busy,
    output logic                done,
    output logic                err
);

    localparam int W = 4 * DIGITS;

    timer_state_t   state_r;
    timer_state_t   state_next_s;
    logic [W-1:0]   q_r;
    logic [W-1:0]   q_next_s;
    logic [W-1:0]   q_dec_s;
    logic [DIGITS:0] borrow_s;
    logic           done_r;
    logic           done_next_s;
    logic           err_r;
    logic           err_next_s;
    logic           reject_r;
    logic           reject_s;
    logic           load_req_s;
    logic           load_legal_s;
    logic           q_zero_s;
    logic           q_one_s;

    // Every digit of a load word must be a legal BCD digit.
    function automatic logic word_is_bcd(input logic [W-1:0] v);
        logic ok;
        ok = 1'b1;
        for (int i = 0; i < DIGITS; i++) begin
            if (!digit_is_valid(v[4*i +: 4])) begin
                ok = 1'b0;
            end else begin
                ok = ok;
            end
        end
        return ok;
    endfunction

    // Ripple-borrow decrement chain; en is the borrow into the LSD so the
    // chain output equals q_r when paused.
    assign borrow_s[0] = en;
    for (genvar g = 0; g < DIGITS; g++) begin : g_digit
        bcd_digit_dec u_dec (
            .digit_in   (q_r[4*g +: 4]),
            .borrow_in  (borrow_s[g]),
            .digit_out  (q_dec_s[4*g +: 4]),
            .borrow_out (borrow_s[g+1])
        );
    end

    assign load_ready   = (state_r == IDLE) || (state_r == ARMED);
    assign load_req_s   = load_valid && load_ready;
    assign load_legal_s = word_is_bcd(load_bcd);
    assign q_zero_s     = (q_r == '0);
    assign q_one_s      = (q_r == W'(1));

    // Next-state and next-count logic; priority abort > load > start > en.
    always_comb begin
        state_next_s = state_r;
        q_next_s     = q_r;
        done_next_s  = 1'b0;
        reject_s     = 1'b0;
        case (state_r)
            IDLE: begin
                if (load_req_s) begin
                    if (load_legal_s) begin
                        q_next_s     = load_bcd;
                        state_next_s = ARMED;
                    end else begin
                        reject_s = 1'b1;
                    end
                end else begin
                    state_next_s = IDLE;
                end
            end
            ARMED: begin
                if (abort) begin
                    state_next_s = IDLE;
                    q_next_s     = '0;
                end else if (load_req_s) begin
                    if (load_legal_s) begin
                        q_next_s = load_bcd;
                    end else begin
                        reject_s = 1'b1;
                    end
                end else if (start) begin
                    if (q_zero_s) begin
                        state_next_s = DONE;
                        done_next_s  = 1'b1;
                    end else begin
                        state_next_s = RUN;
                    end
                end else begin
                    state_next_s = ARMED;
                end
            end
            RUN: begin
                if (abort) begin
                    state_next_s = IDLE;
                    q_next_s     = '0;
                end else if (en) begin
                    // A borrow out of the MSD means q was already zero;
                    // finish rather than wrap to all nines.
                    if (q_one_s || borrow_s[DIGITS]) begin
                        q_next_s     = '0;
                        state_next_s = DONE;
                        done_next_s  = 1'b1;
                    end else begin
                        q_next_s = q_dec_s;
                    end
                end else begin
                    q_next_s = q_r;
                end
            end
            DONE: begin
                state_next_s = IDLE;
                q_next_s     = '0;
            end
            default: begin
                state_next_s = IDLE;
                q_next_s     = '0;
            end
        endcase
        // Only the first cycle of a held rejected load raises err.
        if (reject_s && !reject_r) begin
            err_next_s = 1'b1;
        end else begin
            err_next_s = 1'b0;
        end
    end

    // State, count and pulse registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r  <= IDLE;
            q_r      <= '0;
            done_r   <= 1'b0;
            err_r    <= 1'b0;
            reject_r <= 1'b0;
        end else begin
            state_r  <= state_next_s;
            q_r      <= q_next_s;
            done_r   <= done_next_s;
            err_r    <= err_next_s;
            reject_r <= reject_s;
        end
    end

    assign q    = q_r;
    assign busy = (state_r == RUN);
    assign done = done_r;
    assign err  = err_r;

endmodule

// File: tb/tb_bcd_down_timer.sv
// Directed self-checking bench for bcd_down_timer (DIGITS = 2).
module tb_bcd_down_timer;

    logic       clk;
    logic       reset_n;
    logic       load_valid;
    logic [7:0] load_bcd;
    logic       load_ready;
    logic       start;
    logic       en;
    logic       abort;
    logic [7:0] q;
    logic       busy;
    logic       done;
    logic       err;

    int errors;
    int checks;

    bcd_down_timer #(.DIGITS(2)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .load_valid (load_valid),
        .load_bcd   (load_bcd),
        .load_ready (load_ready),
        .start      (start),
        .en         (en),
        .abort      (abort),
        .q          (q),
        .busy       (busy),
        .done       (done),
        .err        (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one clock and settle just after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] exp_q;
        errors     = 0;
        checks     = 0;
        reset_n    = 1'b0;
        load_valid = 1'b0;
        load_bcd   = 8'h00;
        start      = 1'b0;
        en         = 1'b0;
        abort      = 1'b0;

        // Reset state
        #12;
        chk("rst_q", q, 16'h0000);
        chk("rst_busy", busy, 16'h0000);
        chk("rst_done", done, 16'h0000);
        chk("rst_err", err, 16'h0000);
        chk("rst_ready", load_ready, 16'h0001);
        reset_n = 1'b1;
        tick();

        // Count down from 12
        load_valid = 1'b1;
        load_bcd   = 8'h12;
        tick();
        load_valid = 1'b0;
        chk("cd_load_q", q, 16'h0012);
        chk("cd_armed_busy", busy, 16'h0000);
        chk("cd_armed_ready", load_ready, 16'h0001);
        start = 1'b1;
        en    = 1'b1;
        tick();
        start = 1'b0;
        chk("cd_run_busy", busy, 16'h0001);
        chk("cd_run_q", q, 16'h0012);
        chk("cd_run_ready", load_ready, 16'h0000);
        for (int k = 11; k >= 1; k--) begin
            tick();
            exp_q = 8'((k / 10) * 16 + (k % 10));
            chk("cd_step_q", q, {8'h00, exp_q});
            chk("cd_step_done", done, 16'h0000);
        end
        tick();
        chk("cd_zero_q", q, 16'h0000);
        chk("cd_zero_done", done, 16'h0001);
        chk("cd_zero_busy", busy, 16'h0000);
        tick();
        chk("cd_idle_done", done, 16'h0000);
        chk("cd_idle_ready", load_ready, 16'h0001);
        en = 1'b0;

        // Borrow and pause from 20
        load_valid = 1'b1;
        load_bcd   = 8'h20;
        tick();
        load_valid = 1'b0;
        start      = 1'b1;
        tick();
        start = 1'b0;
        chk("bp_run_q", q, 16'h0020);
        en = 1'b1;
        tick();
        chk("bp_borrow_q", q, 16'h0019);
        en = 1'b0;
        repeat (5) tick();
        chk("bp_pause_q", q, 16'h0019);
        chk("bp_pause_busy", busy, 16'h0001);
        en = 1'b1;
        tick();
        chk("bp_resume_q", q, 16'h0018);
        repeat (14) tick();
        chk("ab_pre_q", q, 16'h0004);

        // Abort during RUN at 04
        abort = 1'b1;
        tick();
        abort = 1'b0;
        en    = 1'b0;
        chk("ab_q", q, 16'h0000);
        chk("ab_busy", busy, 16'h0000);
        chk("ab_done", done, 16'h0000);
        chk("ab_ready", load_ready, 16'h0001);
        tick();
        chk("ab_nodone", done, 16'h0000);

        // Illegal load held for two cycles, then a legal one
        load_valid = 1'b1;
        load_bcd   = 8'h3A;
        tick();
        chk("il_err", err, 16'h0001);
        chk("il_q", q, 16'h0000);
        chk("il_ready", load_ready, 16'h0001);
        tick();
        chk("il_err_once", err, 16'h0000);
        load_bcd = 8'hB1;
        tick();
        load_bcd = 8'h05;
        tick();
        load_valid = 1'b0;
        chk("il_ok_err", err, 16'h0000);
        chk("il_ok_q", q, 16'h0005);
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("il_armed_run", busy, 16'h0001);
        chk("il_hold_q", q, 16'h0005);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("il_abort_q", q, 16'h0000);

        // Zero start: done with no RUN
        load_valid = 1'b1;
        load_bcd   = 8'h00;
        tick();
        load_valid = 1'b0;
        start      = 1'b1;
        tick();
        start = 1'b0;
        chk("zs_done", done, 16'h0001);
        chk("zs_busy", busy, 16'h0000);
        chk("zs_q", q, 16'h0000);
        tick();
        chk("zs_done_off", done, 16'h0000);

        // Load in the same cycle as start wins
        load_valid = 1'b1;
        load_bcd   = 8'h03;
        tick();
        load_bcd = 8'h07;
        start    = 1'b1;
        tick();
        load_valid = 1'b0;
        chk("pr_q", q, 16'h0007);
        chk("pr_busy", busy, 16'h0000);
        tick();
        start = 1'b0;
        chk("pr_run_busy", busy, 16'h0001);
        chk("pr_run_q", q, 16'h0007);
        abort = 1'b1;
        tick();
        abort = 1'b0;

        // Asynchronous reset mid-RUN at 37
        load_valid = 1'b1;
        load_bcd   = 8'h37;
        tick();
        load_valid = 1'b0;
        start      = 1'b1;
        tick();
        chk("rr_busy", busy, 16'h0001);
        chk("rr_q", q, 16'h0037);
        #2;
        reset_n = 1'b0;
        #1;
        chk("rr_async_q", q, 16'h0000);
        chk("rr_async_busy", busy, 16'h0000);
        chk("rr_async_ready", load_ready, 16'h0001);
        #3;
        reset_n = 1'b1;
        en      = 1'b1;
        repeat (3) tick();
        chk("rr_idle_busy", busy, 16'h0000);
        chk("rr_idle_done", done, 16'h0000);
        chk("rr_idle_q", q, 16'h0000);
        start = 1'b0;
        en    = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
